// File: rtl/apb_efpga_hwce_arb.sv
// apb_efpga_hwce_arb: round-robin share of the HWCE APB port; APB_HWCE_ARB_TIMEOUT_EN adds an access timeout.
module apb_efpga_hwce_arb #(
  parameter int NUM_REQ             = 2,
  parameter int APB_HWCE_ADDR_WIDTH = 7,
  parameter int TIMEOUT_CYCLES      = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_psel_i,
  input  logic [NUM_REQ-1:0]                 req_penable_i,
  input  logic [NUM_REQ-1:0]                 req_pwrite_i,
  input  logic [NUM_REQ*APB_HWCE_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*32-1:0]              req_pwdata_i,
  output logic [NUM_REQ*32-1:0]              req_prdata_o,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic [NUM_REQ-1:0]                 req_pslverr_o,
  output logic                               hwce_psel_o,
  output logic                               hwce_penable_o,
  output logic                               hwce_pwrite_o,
  output logic [APB_HWCE_ADDR_WIDTH-1:0]     hwce_addr_o,
  output logic [31:0]                        hwce_pwdata_o,
  input  logic [31:0]                        hwce_prdata_i,
  input  logic                               hwce_ready_i,
  input  logic                               hwce_pslverr_i,
  output logic [NUM_REQ-1:0]                 grant_o,
  output logic                               busy_o
`ifdef APB_HWCE_ARB_TIMEOUT_EN
  , output logic                             timeout_o
`endif
);
  localparam int W  = APB_HWCE_ADDR_WIDTH;
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, gidx_q, gidx_d, sel;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic write_q, write_d, found, to, done;
  assign done = (state_q == ACCESS) && (hwce_ready_i || to);
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && req_psel_i[(int'(rr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        sel   = IW'((int'(rr_q) + i) % NUM_REQ);
      end
  end
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    if (state_q == IDLE && found) begin
      state_d = SETUP;
      gidx_d  = sel;
      grant_d = NUM_REQ'(1) << sel;
      addr_d  = req_addr_i[int'(sel)*W +: W];
      wdata_d = req_pwdata_i[int'(sel)*32 +: 32];
      write_d = req_pwrite_i[sel];
    end else if (state_q == SETUP) begin
      state_d = ACCESS;
    end else if (done) begin
      state_d = IDLE;
      grant_d = '0;
      rr_d    = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
`ifdef APB_HWCE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic timeout_q;
  assign to        = (state_q == ACCESS) && !hwce_ready_i && (cnt_q == CW'(TIMEOUT_CYCLES));
  assign timeout_o = timeout_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= (state_q == SETUP) ? '0 :
                   (state_q == ACCESS && !hwce_ready_i && !to) ? cnt_q + 1'b1 : cnt_q;
      timeout_q <= timeout_q | to;
    end
`else
  assign to = 1'b0;
`endif
  // A response reaches the requester only while it still holds a valid access phase.
  always_comb begin
    req_ready_o   = '0;
    req_pslverr_o = '0;
    req_prdata_o  = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (done && grant_q[k] && req_psel_i[k] && req_penable_i[k]) begin
        req_ready_o[k]            = 1'b1;
        req_pslverr_o[k]          = to | hwce_pslverr_i;
        req_prdata_o[k*32 +: 32]  = to ? 32'hDEADBEEF : hwce_prdata_i;
      end
  end
  assign hwce_psel_o    = state_q != IDLE;
  assign hwce_penable_o = state_q == ACCESS;
  assign busy_o         = state_q != IDLE;
  assign hwce_pwrite_o  = write_q;
  assign hwce_addr_o    = addr_q;
  assign hwce_pwdata_o  = wdata_q;
  assign grant_o        = grant_q;
endmodule

// File: tb/tb_apb_efpga_hwce_arb.sv
// tb_apb_efpga_hwce_arb: randomized round-robin scoreboard bench for apb_efpga_hwce_arb (optional APB_HWCE_ARB_TIMEOUT_EN block).
module tb_apb_efpga_hwce_arb;
  localparam int N = 2;
  localparam int W = 7;
  logic clk = 1'b0, rst;
  logic [N-1:0] psel, pen, pwr, rdy, serr, grant;
  logic [N*W-1:0] paddr;
  logic [N*32-1:0] pwdata, prdata;
  logic hpsel, hpen, hpwr, hready, hserr, busy;
  logic [W-1:0] haddr;
  logic [31:0] hwdata, hrdata;
`ifdef APB_HWCE_ARB_TIMEOUT_EN
  logic tmo;
`endif
  logic [W-1:0] m_addr [N];
  logic [31:0]  m_wd   [N];
  logic         m_wr   [N];
  logic         act    [N];
  int n_chk = 0, n_err = 0, ptr = 0;
  always #5 clk = ~clk;
  apb_efpga_hwce_arb #(.NUM_REQ(N), .APB_HWCE_ADDR_WIDTH(W), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_psel_i(psel), .req_penable_i(pen), .req_pwrite_i(pwr),
    .req_addr_i(paddr), .req_pwdata_i(pwdata), .req_prdata_o(prdata),
    .req_ready_o(rdy), .req_pslverr_o(serr),
    .hwce_psel_o(hpsel), .hwce_penable_o(hpen), .hwce_pwrite_o(hpwr),
    .hwce_addr_o(haddr), .hwce_pwdata_o(hwdata), .hwce_prdata_i(hrdata),
    .hwce_ready_i(hready), .hwce_pslverr_i(hserr),
    .grant_o(grant), .busy_o(busy)
`ifdef APB_HWCE_ARB_TIMEOUT_EN
    , .timeout_o(tmo)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start(input int k, input logic [W-1:0] a, input logic [31:0] d, input logic wr);
    act[k] = 1'b1; m_addr[k] = a; m_wd[k] = d; m_wr[k] = wr;
    psel[k] = 1'b1; pen[k] = 1'b0; pwr[k] = wr;
    paddr[k*W +: W] = a; pwdata[k*32 +: 32] = d;
  endtask
  // Called just after a negedge with the arbiter idle; serves one transfer with w HWCE wait states.
  task automatic xfer(input int w, input logic [31:0] d, input logic e);
    int win = -1;
    for (int i = 0; i < N; i++) if (win < 0 && act[(ptr + i) % N]) win = (ptr + i) % N;
    @(negedge clk);
    hready = 1'($urandom); #1;
    chk("setup_psel", hpsel, 1); chk("setup_pen", hpen, 0); chk("setup_busy", busy, 1);
    chk("grant", grant, 64'(1) << win); chk("addr", haddr, m_addr[win]);
    chk("wdata", hwdata, m_wd[win]); chk("write", hpwr, m_wr[win]); chk("setup_rdy", rdy, 0);
    for (int k = 0; k < N; k++) pen[k] = psel[k];
    for (int c = 0; c <= w; c++) begin
      @(negedge clk);
      hready = (c == w); hrdata = (c == w) ? d : $urandom; hserr = (c == w) ? e : 1'($urandom); #1;
      chk("acc_sel", {hpsel, hpen}, 2'b11); chk("acc_addr", haddr, m_addr[win]);
      chk("ready", rdy, (c == w) ? 64'(1) << win : 0);
      chk("prdata", prdata, (c == w) ? 64'(d) << (32 * win) : 0);
      chk("pslverr", serr, (c == w && e) ? 64'(1) << win : 0);
    end
    @(negedge clk);
    hready = 1'b0; act[win] = 1'b0; psel[win] = 1'b0; pen[win] = 1'b0; ptr = (win + 1) % N; #1;
    chk("idle_busy", busy, 0); chk("idle_psel", {hpsel, hpen}, 0); chk("idle_grant", grant, 0);
  endtask
  initial begin
    rst = 1'b1; psel = '0; pen = '0; pwr = '0; paddr = '0; pwdata = '0;
    hready = 1'b0; hrdata = '0; hserr = 1'b0;
    for (int k = 0; k < N; k++) act[k] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out", {hpsel, hpen, hpwr, haddr, hwdata, grant, busy, rdy, serr}, 0);
    chk("rst_prdata", prdata, 0);
    @(negedge clk); rst = 1'b0;
    start(0, 7'h21, 32'h1, 1'b1); start(1, 7'h22, 32'h2, 1'b1);
    xfer(0, 32'h0, 1'b0); xfer(0, 32'h0, 1'b0);
    start(0, 7'h10, 32'h0, 1'b0); xfer(0, 32'h00DA41DE, 1'b0);
    start(0, 7'h11, 32'h0, 1'b0); xfer(5, 32'h12345678, 1'b0);
    start(0, 7'h12, 32'hA5A5, 1'b1); start(1, 7'h13, 32'h5A5A, 1'b1);
    xfer(1, 32'h0, 1'b1); xfer(0, 32'h0, 1'b0);
    start(1, 7'h33, 32'h0, 1'b0);
    @(negedge clk); #1; chk("rst_setup", {hpsel, hpen}, 2'b10);
    pen[1] = 1'b1;
    @(negedge clk); hready = 1'b0; #1;
    chk("rst_access", {hpsel, hpen}, 2'b11);
    rst = 1'b1; #1;
    chk("rst_async", {hpsel, hpen, grant, busy, rdy, serr}, 0);
    @(negedge clk); rst = 1'b0; pen[1] = 1'b0; ptr = 0;
    xfer(0, 32'hCAFEF00D, 1'b0);
    repeat (80) begin
      for (int k = 0; k < N; k++)
        if (!act[k] && ($urandom % 3 != 0)) start(k, 7'($urandom), $urandom, 1'($urandom));
      if (!act[0] && !act[1]) start(int'($urandom % N), 7'($urandom), $urandom, 1'($urandom));
      xfer(($urandom % 5 == 0) ? 5 : int'($urandom_range(0, 3)), $urandom, 1'($urandom));
    end
`ifdef APB_HWCE_ARB_TIMEOUT_EN
    while (act[0] || act[1]) xfer(0, $urandom, 1'b0);
    chk("tmo_pre", tmo, 0);
    start(0, 7'h44, 32'h0, 1'b0);
    @(negedge clk); pen[0] = 1'b1; hready = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk); #1;
      chk("tmo_ready", rdy, (c == 4) ? 1 : 0);
      if (c == 4) begin
        chk("tmo_err", serr, 1); chk("tmo_data", prdata[31:0], 32'hDEADBEEF); chk("tmo_sel", {hpsel, hpen}, 2'b11);
      end
    end
    @(negedge clk); act[0] = 1'b0; psel[0] = 1'b0; pen[0] = 1'b0; #1;
    chk("tmo_idle", {hpsel, hpen, busy}, 0); chk("tmo_sticky", tmo, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
